// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one pipelined CORDIC rotator among NUM_REQ requesters.
// Optional: define CORDIC_ARB_STATS_EN to add the 16-bit op_count accept counter.
module cordic_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 9
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [9*NUM_REQ-1:0]  req_x,
  input  logic [9*NUM_REQ-1:0]  req_y,
  input  logic [9*NUM_REQ-1:0]  req_angle,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [9*NUM_REQ-1:0]  rsp_sine,
  output logic [9*NUM_REQ-1:0]  rsp_cosine,
  output logic [8:0]            cordic_x,
  output logic [8:0]            cordic_y,
  output logic [8:0]            cordic_angle,
  input  logic [8:0]            cordic_sine,
  input  logic [8:0]            cordic_cosine
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam int unsigned DW        = 9;
  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW        = IDX_W + 1;
  localparam int unsigned TAG_DEPTH = LATENCY - 1;

  logic [NUM_REQ-1:0]   busy;
  logic [NUM_REQ-1:0]   eligible;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 accept;
  logic [CW-1:0]        cand;

  logic [TAG_DEPTH-1:0] tag_valid;
  logic [IDX_W-1:0]     tag_idx [TAG_DEPTH];
  logic                 cap_valid;
  logic [IDX_W-1:0]     cap_idx;

  assign eligible = req_valid & ~busy;
  assign accept   = grant_valid & rst_n;

  // First eligible requester at or above ptr, wrapping to 0.
  always_comb begin : grant_search
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_valid && eligible[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin : operand_mux
    req_ready    = '0;
    cordic_x     = '0;
    cordic_y     = '0;
    cordic_angle = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && grant_idx == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        cordic_x     = req_x[i*DW +: DW];
        cordic_y     = req_y[i*DW +: DW];
        cordic_angle = req_angle[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clock) begin : sched_state
    if (!rst_n) begin
      ptr  <= '0;
      busy <= '0;
    end else begin
      if (accept) ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) busy[i] <= 1'b0;
        if (accept && grant_idx == IDX_W'(i)) busy[i] <= 1'b1;
      end
    end
  end

  // CORDIC output settles after edge LATENCY-1, so the retiring tag waits one more stage for the capture edge.
  always_ff @(posedge clock) begin : tag_pipe
    if (!rst_n) begin
      tag_valid <= '0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      for (int unsigned k = 0; k < TAG_DEPTH; k++) tag_idx[k] <= '0;
    end else begin
      tag_valid[0] <= accept;
      tag_idx[0]   <= grant_idx;
      for (int unsigned k = 1; k < TAG_DEPTH; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
      cap_valid <= tag_valid[TAG_DEPTH-1];
      cap_idx   <= tag_idx[TAG_DEPTH-1];
    end
  end

  always_ff @(posedge clock) begin : rsp_regs
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_sine   <= '0;
      rsp_cosine <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
        if (cap_valid && cap_idx == IDX_W'(i)) begin
          rsp_valid[i]            <= 1'b1;
          rsp_sine[i*DW +: DW]    <= cordic_sine;
          rsp_cosine[i*DW +: DW]  <= cordic_cosine;
        end
      end
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  always_ff @(posedge clock) begin : stats
    if (!rst_n) op_count <= '0;
    else if (accept) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: reference scheduler model plus response scoreboard,
// driven against a behavioural 9-stage stand-in for the CORDIC core.
module tb_cordic_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 9;
  localparam int unsigned DW  = 9;

  typedef struct {
    int         idx;
    logic [8:0] s;
    logic [8:0] c;
    int         due;
  } exp_t;

  logic             clock = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [9*N-1:0]   req_x, req_y, req_angle;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [9*N-1:0]   rsp_sine, rsp_cosine;
  logic [8:0]       cordic_x, cordic_y, cordic_angle;
  logic [8:0]       cordic_sine, cordic_cosine;
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0]      op_count;
`endif

  logic [8:0] bx [N];
  logic [8:0] by [N];
  logic [8:0] ba [N];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         arrivals = 0;
  int         last_grant;
  int         ref_ptr;
  logic [N-1:0] ref_busy, ref_rv, drop_mask;
  logic [15:0]  ref_ops;
  logic [8:0] hold_s [N];
  logic [8:0] hold_c [N];
  exp_t       sb[$];
  int         glog_idx[$];
  int         glog_edge[$];

  always #5 clock = ~clock;

  cordic_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_angle    (req_angle),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_sine     (rsp_sine),
    .rsp_cosine   (rsp_cosine),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_angle (cordic_angle),
    .cordic_sine  (cordic_sine),
    .cordic_cosine(cordic_cosine)
`ifdef CORDIC_ARB_STATS_EN
    ,
    .op_count     (op_count)
`endif
  );

  always_comb begin
    req_x = '0;
    req_y = '0;
    req_angle = '0;
    for (int i = 0; i < N; i++) begin
      req_x[i*DW +: DW]     = bx[i];
      req_y[i*DW +: DW]     = by[i];
      req_angle[i*DW +: DW] = ba[i];
    end
  end

  // Arbitrary but operand-sensitive stand-in for the rotator; the arbiter never inspects the values.
  function automatic logic [17:0] cordic_fn(input logic [8:0] x, input logic [8:0] y, input logic [8:0] a);
    logic [8:0] s, c;
    s = x ^ {a[3:0], a[8:4]} ^ 9'h0A5;
    c = y + a + 9'd1;
    return {s, c};
  endfunction

  logic [17:0] cpipe [LAT];
  always_ff @(posedge clock) begin
    cpipe[0] <= cordic_fn(cordic_x, cordic_y, cordic_angle);
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign {cordic_sine, cordic_cosine} = cpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Sampled at negedge: compares against the model, then advances the model for the coming edge.
  task automatic monitor();
    logic [N-1:0] exp_ready;
    logic [17:0]  sc;
    int           g;
    exp_t         e;
    exp_ready  = '0;
    g          = -1;
    last_grant = -1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      ref_rv[e.idx] = 1'b1;
      hold_s[e.idx] = e.s;
      hold_c[e.idx] = e.c;
      arrivals++;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(ref_rv));
    for (int i = 0; i < N; i++) begin
      if (ref_rv[i] && rsp_valid[i]) begin
        chk($sformatf("rsp_sine[%0d]", i), 64'(rsp_sine[i*DW +: DW]), 64'(hold_s[i]));
        chk($sformatf("rsp_cosine[%0d]", i), 64'(rsp_cosine[i*DW +: DW]), 64'(hold_c[i]));
      end
    end
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ref_ptr + k) % N;
        if (g < 0 && req_valid[c] && !ref_busy[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) chk("cordic_ops", 64'({cordic_x, cordic_y, cordic_angle}), 64'({bx[g], by[g], ba[g]}));
    else        chk("cordic_idle", 64'({cordic_x, cordic_y, cordic_angle}), 64'(0));
`ifdef CORDIC_ARB_STATS_EN
    chk("op_count", 64'(op_count), 64'(ref_ops));
`endif
    for (int i = 0; i < N; i++) begin
      if (ref_rv[i] && rsp_ready[i]) begin
        ref_rv[i]   = 1'b0;
        ref_busy[i] = 1'b0;
      end
    end
    if (g >= 0) begin
      sc    = cordic_fn(bx[g], by[g], ba[g]);
      e.idx = g;
      e.s   = sc[17:9];
      e.c   = sc[8:0];
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
      ref_busy[g] = 1'b1;
      ref_ptr     = (g + 1) % N;
      ref_ops     = ref_ops + 16'd1;
      glog_idx.push_back(g);
      glog_edge.push_back(cyc + 1);
      last_grant = g;
    end
    if (!rst_n) begin
      ref_ptr  = 0;
      ref_busy = '0;
      ref_rv   = '0;
      ref_ops  = '0;
      sb.delete();
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    cyc++;
    #1;
    if (last_grant >= 0 && drop_mask[last_grant]) req_valid[last_grant] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_op(input int i, input logic [8:0] x, input logic [8:0] y, input logic [8:0] a);
    bx[i] = x;
    by[i] = y;
    ba[i] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_sine", 64'(rsp_sine), 64'(0));
    chk("rst_rsp_cosine", 64'(rsp_cosine), 64'(0));
    rst_n = 1'b1;
  endtask

  function automatic int count_grants(input int base, input int idx);
    int n;
    n = 0;
    for (int k = base; k < glog_idx.size(); k++) if (glog_idx[k] == idx) n++;
    return n;
  endfunction

  initial begin
    int base, a0, n2, n3;
    logic alt;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    drop_mask = '1;
    ref_ptr = 0;
    ref_busy = '0;
    ref_rv = '0;
    ref_ops = '0;
    for (int i = 0; i < N; i++) begin
      set_op(i, 9'd0, 9'd0, 9'd0);
      hold_s[i] = '0;
      hold_c[i] = '0;
    end

    // Reset: request lines high must not be granted, outputs cleared
    steps(2);
    req_valid = 4'b1111;
    set_op(2, 9'd33, 9'd44, 9'd55);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_cordic", 64'({cordic_x, cordic_y, cordic_angle}), 64'(0));
    step();
    req_valid = '0;
    do_reset();

    // Single request from requester 0
    rsp_ready = 4'b1111;
    set_op(0, 9'h04D, 9'd0, 9'd0);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0001));
    a0 = arrivals;
    steps(13);
    chk("single_arrivals", 64'(arrivals), 64'(a0 + 1));

    // All four from reset: grants 0,1,2,3 on consecutive edges
    do_reset();
    set_op(0, 9'd10, 9'd5, 9'd0);
    set_op(1, 9'd20, 9'd6, 9'd64);
    set_op(2, 9'd30, 9'd7, 9'h1C0);
    set_op(3, 9'd40, 9'd8, 9'd32);
    base = glog_idx.size();
    req_valid = 4'b1111;
    steps(16);
    chk("all4_count", 64'(glog_idx.size() - base), 64'(4));
    if (glog_idx.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("all4_idx%0d", k), 64'(glog_idx[base+k]), 64'(k));
        chk($sformatf("all4_edge%0d", k), 64'(glog_edge[base+k] - glog_edge[base]), 64'(k));
      end
    end

    // Backpressure on requester 1 while it keeps requesting
    rsp_ready = 4'b1101;
    drop_mask = 4'b1101;
    set_op(0, 9'd101, 9'd3, 9'd17);
    set_op(1, 9'd202, 9'd4, 9'd18);
    set_op(2, 9'd303, 9'd5, 9'd19);
    set_op(3, 9'd404, 9'd6, 9'd20);
    base = glog_idx.size();
    req_valid = 4'b1111;
    steps(12);
    req_valid = req_valid | 4'b0101;
    steps(14);
    chk("bp_grants_req1", 64'(count_grants(base, 1)), 64'(1));
    chk("bp_grants_req0", 64'(count_grants(base, 0)), 64'(2));
    chk("bp_grants_req2", 64'(count_grants(base, 2)), 64'(2));
    chk("bp_held", 64'(rsp_valid), 64'(4'b0010));
    rsp_ready[1] = 1'b1;
    step();
    chk("bp_regrant", 64'(req_ready), 64'(4'b0010));
    drop_mask[1] = 1'b1;
    steps(13);

    // Fairness between 2 and 3 with ptr parked at 2
    do_reset();
    rsp_ready = 4'b1111;
    drop_mask = 4'b1111;
    req_valid = 4'b0010;
    steps(12);
    drop_mask = 4'b0011;
    set_op(2, 9'd77, 9'd88, 9'd99);
    set_op(3, 9'd11, 9'd22, 9'h1F0);
    base = glog_idx.size();
    req_valid = 4'b1100;
    steps(40);
    req_valid = '0;
    drop_mask = 4'b1111;
    n2 = count_grants(base, 2);
    n3 = count_grants(base, 3);
    alt = 1'b1;
    for (int k = base + 1; k < glog_idx.size(); k++) if (glog_idx[k] == glog_idx[k-1]) alt = 1'b0;
    chk("fair_req2_min", 64'(n2 >= 3), 64'(1));
    chk("fair_req3_min", 64'(n3 >= 3), 64'(1));
    chk("fair_alternate", 64'(alt), 64'(1));
    if (glog_idx.size() > base) chk("fair_first", 64'(glog_idx[base]), 64'(2));
    steps(12);

    // Reset with two operations in flight discards them
    do_reset();
    set_op(0, 9'd5, 9'd9, 9'd13);
    set_op(1, 9'd6, 9'd10, 9'd14);
    req_valid = 4'b0011;
    steps(3);
    a0 = arrivals;
    do_reset();
    steps(12);
    chk("mid_rst_no_arrivals", 64'(arrivals), 64'(a0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    set_op(2, 9'd123, 9'd45, 9'd67);
    req_valid = 4'b0100;
    steps(13);
    chk("post_rst_arrival", 64'(arrivals), 64'(a0 + 1));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
